// File: rtl/alu_issue_if.sv
// alu_issue_if: bundle of request, ALU-drive and response signals around the
// ALU issue controller. The slave modport is the controller's view; the master
// modport is the view of the surrounding environment (requester, ALU, consumer).
interface alu_issue_if #(
    parameter int W      = 8,
    parameter int MODE_W = 4
);
    // request side
    logic              req_valid;
    logic              req_ready;
    logic [W-1:0]      req_a;
    logic [W-1:0]      req_b;
    logic [MODE_W-1:0] req_mode;

    // ALU drive / capture
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [MODE_W-1:0] alu_mode;
    logic              alu_ee;
    logic              alu_eo;
    logic [W-1:0]      alu_result;
    logic              alu_carry;

    // response side
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [W-1:0]      rsp_hi;
    logic              rsp_zero;
    logic              rsp_carry;

    modport slave (
        input  req_valid, req_a, req_b, req_mode,
        output req_ready,
        output alu_a, alu_b, alu_mode, alu_ee, alu_eo,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_data, rsp_hi, rsp_zero, rsp_carry,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_mode,
        input  req_ready,
        input  alu_a, alu_b, alu_mode, alu_ee, alu_eo,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_data, rsp_hi, rsp_zero, rsp_carry,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one operation at a time through the 8-bit ALU.
// A request is latched into the ALU operand/mode registers, the ALU is enabled
// for a settle cycle and a sample cycle, and the result, carry and a locally
// derived zero flag are registered and offered on the response handshake.
// The ALU's own zero flag is one step stale and is deliberately not used.
//
// Optional feature, macro ALU_ISSUE_MULW_EN: a multiply-low request also runs
// a second drive/sample pair with the multiply-high mode, filling rsp_hi and
// making rsp_zero cover the full 16-bit product. Without the macro the high
// pass is never entered and rsp_hi is constant zero.
module alu_issue_ctrl #(
    parameter int                W        = 8,
    parameter int                MODE_W   = 4,
    parameter logic [MODE_W-1:0] MODE_MLO = 4'b1101,
    parameter logic [MODE_W-1:0] MODE_MHI = 4'b1110
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);

`ifdef ALU_ISSUE_MULW_EN
    localparam logic MULW_ON = 1'b1;
`else
    localparam logic MULW_ON = 1'b0;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DRIVE     = 3'd1;
    localparam logic [2:0] S_SAMPLE    = 3'd2;
    localparam logic [2:0] S_DRIVE_HI  = 3'd3;
    localparam logic [2:0] S_SAMPLE_HI = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;

    logic              req_ready_r;
    logic              rsp_valid_r;
    logic              alu_en_r;

    logic [W-1:0]      alu_a_r;
    logic [W-1:0]      alu_b_r;
    logic [MODE_W-1:0] alu_mode_r;

    logic [W-1:0]      rsp_data_r;
    logic [W-1:0]      rsp_hi_r;
    logic              rsp_zero_r;
    logic              rsp_carry_r;

    logic              mulw_s;
    logic              res_zero_s;

    // High pass is only taken for a multiply-low op when the feature is built in.
    always_comb begin
        mulw_s     = MULW_ON && (alu_mode_r == MODE_MLO);
        res_zero_s = (bus.alu_result == {W{1'b0}});
    end

    // Next-state logic for the issue sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = S_DRIVE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DRIVE: begin
                state_nxt_s = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (mulw_s) begin
                    state_nxt_s = S_DRIVE_HI;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            S_DRIVE_HI: begin
                state_nxt_s = S_SAMPLE_HI;
            end
            S_SAMPLE_HI: begin
                state_nxt_s = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register plus handshake/enable outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            alu_en_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == S_IDLE);
            rsp_valid_r <= (state_nxt_s == S_RESP);
            alu_en_r    <= (state_nxt_s == S_DRIVE)    || (state_nxt_s == S_SAMPLE) ||
                           (state_nxt_s == S_DRIVE_HI) || (state_nxt_s == S_SAMPLE_HI);
        end
    end

    // Operand latch on accept, mode switch for the high pass, result capture on samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_r     <= {W{1'b0}};
            alu_b_r     <= {W{1'b0}};
            alu_mode_r  <= {MODE_W{1'b0}};
            rsp_data_r  <= {W{1'b0}};
            rsp_hi_r    <= {W{1'b0}};
            rsp_zero_r  <= 1'b0;
            rsp_carry_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        alu_a_r    <= bus.req_a;
                        alu_b_r    <= bus.req_b;
                        alu_mode_r <= bus.req_mode;
                    end
                end
                S_SAMPLE: begin
                    rsp_data_r  <= bus.alu_result;
                    rsp_carry_r <= bus.alu_carry;
                    rsp_zero_r  <= res_zero_s;
                    rsp_hi_r    <= {W{1'b0}};
                    if (mulw_s) begin
                        alu_mode_r <= MODE_MHI;
                    end
                end
                S_SAMPLE_HI: begin
                    // Zero covers the full product: low byte already held in rsp_data_r.
                    rsp_hi_r    <= MULW_ON ? bus.alu_result : {W{1'b0}};
                    rsp_carry_r <= bus.alu_carry;
                    rsp_zero_r  <= res_zero_s && (rsp_data_r == {W{1'b0}});
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.alu_ee    = alu_en_r;
    assign bus.alu_eo    = alu_en_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_mode  = alu_mode_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_hi    = rsp_hi_r;
    assign bus.rsp_zero  = rsp_zero_r;
    assign bus.rsp_carry = rsp_carry_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl. A small behavioural
// ALU supplies alu_result/alu_carry; all expected values are hand-computed.
module tb_alu_issue_ctrl;

    localparam logic [3:0] M_ADD = 4'h0;
    localparam logic [3:0] M_AND = 4'h2;
    localparam logic [3:0] M_XOR = 4'h4;
    localparam logic [3:0] M_MLO = 4'hD;
    localparam logic [3:0] M_MHI = 4'hE;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    alu_issue_if #(.W(8), .MODE_W(4)) bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational result and carry from the driven operands.
    logic [8:0]  sum9;
    logic [15:0] prod16;
    always_comb begin
        sum9   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        prod16 = {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
        bus.alu_result = 8'h00;
        bus.alu_carry  = 1'b0;
        case (bus.alu_mode)
            M_ADD: begin bus.alu_result = sum9[7:0]; bus.alu_carry = sum9[8]; end
            M_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            M_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
            M_MLO: bus.alu_result = prod16[7:0];
            M_MHI: bus.alu_result = prod16[15:8];
            default: bus.alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and take the accept edge; returns in the DRIVE cycle.
    task automatic do_req(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_mode  = m;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; passed = 0; failed = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = 8'h00;
        bus.req_b     = 8'h00;
        bus.req_mode  = 4'h0;
        bus.rsp_ready = 1'b1;
        step();
        step();

        // reset state
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_alu_ee",    bus.alu_ee,    1'b0);
        chk("rst_alu_eo",    bus.alu_eo,    1'b0);
        chk("rst_rsp_data",  bus.rsp_data,  8'h00);
        chk("rst_rsp_zero",  bus.rsp_zero,  1'b0);
        chk("rst_alu_a",     bus.alu_a,     8'h00);
        rst_n = 1'b1;
        step();

        // ADD 0x7F + 0x01
        do_req(8'h7F, 8'h01, M_ADD);
        chk("add1_c1_ee",    bus.alu_ee,    1'b1);
        chk("add1_c1_eo",    bus.alu_eo,    1'b1);
        chk("add1_c1_valid", bus.rsp_valid, 1'b0);
        chk("add1_c1_rdy",   bus.req_ready, 1'b0);
        chk("add1_alu_a",    bus.alu_a,     8'h7F);
        step();
        chk("add1_c2_ee",    bus.alu_ee,    1'b1);
        chk("add1_c2_valid", bus.rsp_valid, 1'b0);
        step();
        chk("add1_c3_valid", bus.rsp_valid, 1'b1);
        chk("add1_c3_ee",    bus.alu_ee,    1'b0);
        chk("add1_c3_eo",    bus.alu_eo,    1'b0);
        chk("add1_data",     bus.rsp_data,  8'h80);
        chk("add1_carry",    bus.rsp_carry, 1'b0);
        chk("add1_zero",     bus.rsp_zero,  1'b0);
        chk("add1_hi",       bus.rsp_hi,    8'h00);
        step();
        chk("add1_idle_valid", bus.rsp_valid, 1'b0);
        chk("add1_idle_rdy",   bus.req_ready, 1'b1);
        chk("add1_idle_hold",  bus.rsp_data,  8'h80);

        // ADD 0xFF + 0x01 wraps to zero with carry
        do_req(8'hFF, 8'h01, M_ADD);
        step();
        step();
        chk("add2_valid", bus.rsp_valid, 1'b1);
        chk("add2_data",  bus.rsp_data,  8'h00);
        chk("add2_carry", bus.rsp_carry, 1'b1);
        chk("add2_zero",  bus.rsp_zero,  1'b1);
        step();

        // reset held two cycles in the middle of DRIVE
        do_req(8'h33, 8'h44, M_ADD);
        chk("mid_ee_before_rst", bus.alu_ee, 1'b1);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("mrst_req_ready", bus.req_ready, 1'b1);
        chk("mrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mrst_alu_ee",    bus.alu_ee,    1'b0);
        chk("mrst_rsp_data",  bus.rsp_data,  8'h00);
        chk("mrst_rsp_carry", bus.rsp_carry, 1'b0);
        chk("mrst_rsp_zero",  bus.rsp_zero,  1'b0);
        chk("mrst_rsp_hi",    bus.rsp_hi,    8'h00);
        chk("mrst_alu_a",     bus.alu_a,     8'h00);
        step();
        step();
        chk("mrst_no_rsp",    bus.rsp_valid, 1'b0);

        // backpressure: consumer stalls 5 cycles while a new request waits
        bus.rsp_ready = 1'b0;
        do_req(8'h12, 8'h34, M_ADD);
        step();
        step();
        chk("bp_valid", bus.rsp_valid, 1'b1);
        chk("bp_data",  bus.rsp_data,  8'h46);
        bus.req_valid = 1'b1;
        bus.req_a     = 8'hAA;
        bus.req_b     = 8'h01;
        bus.req_mode  = M_ADD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", bus.rsp_valid, 1'b1);
            chk("bp_hold_data",  bus.rsp_data,  8'h46);
            chk("bp_hold_rdy",   bus.req_ready, 1'b0);
            chk("bp_hold_alu_a", bus.alu_a,     8'h12);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_exit_valid", bus.rsp_valid, 1'b0);
        chk("bp_exit_rdy",   bus.req_ready, 1'b1);
        chk("bp_exit_alu_a", bus.alu_a,     8'h12);
        step();
        bus.req_valid = 1'b0;
        chk("bp_acc_alu_a", bus.alu_a,     8'hAA);
        chk("bp_acc_ee",    bus.alu_ee,    1'b1);
        chk("bp_acc_rdy",   bus.req_ready, 1'b0);
        step();
        step();
        chk("bp2_valid", bus.rsp_valid, 1'b1);
        chk("bp2_data",  bus.rsp_data,  8'hAB);
        step();

        // XOR then AND back to back, both zero
        do_req(8'h5A, 8'h5A, M_XOR);
        bus.req_valid = 1'b1;
        bus.req_a     = 8'hF0;
        bus.req_b     = 8'h0F;
        bus.req_mode  = M_AND;
        step();
        step();
        chk("xor_valid", bus.rsp_valid, 1'b1);
        chk("xor_data",  bus.rsp_data,  8'h00);
        chk("xor_zero",  bus.rsp_zero,  1'b1);
        chk("xor_rdy",   bus.req_ready, 1'b0);
        step();
        chk("xor_exit_rdy",  bus.req_ready, 1'b1);
        chk("xor_exit_mode", bus.alu_mode,  M_XOR);
        step();
        bus.req_valid = 1'b0;
        chk("and_acc_mode", bus.alu_mode, M_AND);
        chk("and_acc_a",    bus.alu_a,    8'hF0);
        step();
        step();
        chk("and_valid", bus.rsp_valid, 1'b1);
        chk("and_data",  bus.rsp_data,  8'h00);
        chk("and_zero",  bus.rsp_zero,  1'b1);
        chk("and_carry", bus.rsp_carry, 1'b0);
        step();

        // multiply low (and high when the feature is built in)
        do_req(8'h10, 8'h20, M_MLO);
        chk("mul_c1_mode", bus.alu_mode, M_MLO);
        step();
        chk("mul_c2_mode", bus.alu_mode, M_MLO);
        step();
`ifdef ALU_ISSUE_MULW_EN
        chk("mul_c3_mode",  bus.alu_mode,  M_MHI);
        chk("mul_c3_valid", bus.rsp_valid, 1'b0);
        chk("mul_c3_ee",    bus.alu_ee,    1'b1);
        step();
        chk("mul_c4_valid", bus.rsp_valid, 1'b0);
        step();
        chk("mul_c5_valid", bus.rsp_valid, 1'b1);
        chk("mul_data",     bus.rsp_data,  8'h00);
        chk("mul_hi",       bus.rsp_hi,    8'h02);
        chk("mul_zero",     bus.rsp_zero,  1'b0);
`else
        chk("mul_c3_valid", bus.rsp_valid, 1'b1);
        chk("mul_data",     bus.rsp_data,  8'h00);
        chk("mul_hi",       bus.rsp_hi,    8'h00);
        chk("mul_zero",     bus.rsp_zero,  1'b1);
`endif
        step();

        // non-multiply op after a multiply clears rsp_hi
        do_req(8'h01, 8'h01, M_ADD);
        step();
        step();
        chk("post_valid", bus.rsp_valid, 1'b1);
        chk("post_data",  bus.rsp_data,  8'h02);
        chk("post_hi",    bus.rsp_hi,    8'h00);
        chk("post_zero",  bus.rsp_zero,  1'b0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the 8-bit ALU.
- Accepts an operation request (two operands plus a 4-bit mode) over a valid/ready handshake, drives the ALU operand, mode and enable inputs, then registers the result and flags.
- Returns the registered result over a second valid/ready handshake.
- Replaces the ALU's combinational, one-step-stale zero flag with a zero flag computed from the captured result.

Parameters:
- W, 8, operand/result width; must match the ALU datapath.
- MODE_W, 4, ALU mode field width.
- MODE_MLO, 4'b1101, mode code for multiply low byte.
- MODE_MHI, 4'b1110, mode code for multiply high byte.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_mode  in  MODE_W  ALU mode
- alu_a  out  W  to ALU in_a
- alu_b  out  W  to ALU in_b
- alu_mode  out  MODE_W  to ALU mode
- alu_ee  out  1  ALU execute enable
- alu_eo  out  1  ALU output enable (bus drive)
- alu_result  in  W  from ALU out
- alu_carry  in  1  from ALU flag_carry
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  W  registered result (low byte for multiply)
- rsp_hi  out  W  registered multiply high byte (0 unless MULW_EN)
- rsp_zero  out  1  rsp_data == 0
- rsp_carry  out  1  registered ALU carry

Behaviour:
- Reset (rst_n low at clock edge):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0; rsp_data, rsp_hi, rsp_carry = 0; rsp_zero=0.
  - alu_a, alu_b and alu_mode operand registers = 0; alu_ee=0, alu_eo=0.
  - Reset mid-operation abandons the operation with no response.
- States: IDLE, DRIVE, SAMPLE, [DRIVE_HI, SAMPLE_HI], RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_a, req_b and req_mode into the alu_* registers, then go to DRIVE.
- DRIVE:
  - alu_ee=1, alu_eo=1; one settle cycle.
  - Go to SAMPLE.
- SAMPLE:
  - alu_ee=1, alu_eo=1.
  - At the end of the cycle: rsp_data <= alu_result; rsp_carry <= alu_carry; rsp_zero <= (alu_result == 0).
  - Go to RESP, or to DRIVE_HI (see Optional Feature).
- RESP:
  - rsp_valid=1; alu_ee=0, alu_eo=0.
  - rsp_data, rsp_hi, rsp_zero and rsp_carry hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE.
- req_ready is 0 in every state except IDLE.
- A request arriving in the same cycle that RESP completes is not accepted until the next cycle. No bypass, no overlap.
- Latency: request accepted at edge N; rsp_valid=1 from cycle N+3 (non-multiply). Throughput is one op per 4 cycles minimum.
- alu_ee is asserted only in the DRIVE/SAMPLE states, so the ALU's internal carry used by ADC/SUB advances once per issued op.
- rsp_zero is derived locally from the sampled result; ALU flag_zero is never used.
- rsp_carry is the ALU carry from the last sample of the op.
- Result registers keep their last values in IDLE.
- alu_* operand and mode registers keep their last values until the next accept.

Optional Feature:
- Macro: ALU_ISSUE_MULW_EN.
- Defined:
  - A request with req_mode == MODE_MLO continues from SAMPLE to DRIVE_HI, with alu_mode switched to MODE_MHI and operands unchanged.
  - DRIVE_HI: ee/eo = 1. SAMPLE_HI: ee/eo = 1; at the end of the cycle rsp_hi <= alu_result and rsp_carry <= alu_carry.
  - rsp_zero reflects {rsp_hi, rsp_data} == 0.
  - Then go to RESP; rsp_valid from cycle N+5.
  - Non-MLO ops write rsp_hi=0.
- Undefined:
  - DRIVE_HI/SAMPLE_HI are absent; MLO is a normal single-byte op.
  - rsp_hi is tied to 0.

Test Plan:
- Reset with rst_n=0 for 2 cycles mid-DRIVE -> next cycle req_ready=1, rsp_valid=0, alu_ee=0, all rsp_* = 0.
- ADD a=0x7F b=0x01 -> rsp_valid at N+3, rsp_data=0x80, rsp_carry=0, rsp_zero=0; alu_ee high exactly 2 cycles.
- ADD a=0xFF b=0x01 -> rsp_data=0x00, rsp_carry=1, rsp_zero=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with req_valid held high and new operands presented -> rsp_data stable, req_ready=0 throughout; second op accepted only after RESP exits.
- XOR a=0x5A b=0x5A, then immediately AND a=0xF0 b=0x0F -> both give rsp_zero=1, data 0x00; second accepted the cycle after the first completes.
- With ALU_ISSUE_MULW_EN, mode MLO a=0x10 b=0x20 -> alu_mode steps MLO then MHI, rsp_data=0x00, rsp_hi=0x02, rsp_zero=0, rsp_valid at N+5. Without the macro -> rsp_hi=0, rsp_zero=1 at N+3.
